// File: rtl/mont_mul_sched_pkg.sv
// Shared types and defaults for the Montgomery multiplier scheduler.
package mont_mul_sched_pkg;

  localparam int WIDTH_DEF   = 256;
  localparam int TIMEOUT_DEF = 300;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mont_mul_sched_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
    last_d = last_q;
    if (gnt[1])      last_d = 1'b1;
    else if (gnt[0]) last_d = 1'b0;
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mont_mul_sched.sv
// Schedules Montgomery multiplications from two requesters onto one external core.
//   state    | meaning
//   ST_IDLE  | waiting for a request; grants one and latches its operands
//   ST_CLEAR | core_rst_n low for one cycle to clear the core
//   ST_RUN   | core_start high; waits for core_done or timeout
//   ST_RESP  | result presented until rsp_ready
module mont_mul_sched
  import mont_mul_sched_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_p,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_p,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             core_rst_n,
  output logic             core_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic [WIDTH-1:0] core_p,
  input  logic [WIDTH-1:0] core_m,
  input  logic             core_done,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] core_a_q, core_a_d;
  logic [WIDTH-1:0] core_b_q, core_b_d;
  logic [WIDTH-1:0] core_p_q, core_p_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic [1:0]       gnt;
  logic             arb_en;

  // Gating with rst_n keeps the readies low while reset is held.
  assign arb_en = (state_q == ST_IDLE) && rst_n;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    core_a_d   = core_a_q;
    core_b_d   = core_b_q;
    core_p_d   = core_p_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt[0]) begin
          core_a_d = req0_a;
          core_b_d = req0_b;
          core_p_d = req0_p;
          rsp_id_d = 1'b0;
          state_d  = ST_CLEAR;
        end else if (gnt[1]) begin
          core_a_d = req1_a;
          core_b_d = req1_b;
          core_p_d = req1_p;
          rsp_id_d = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // core_done is checked first so a completion on the last allowed cycle still succeeds.
        if (core_done) begin
          rsp_data_d = core_m;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    core_rst_n_d = (state_d != ST_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      core_p_q     <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      core_p_q     <= core_p_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign busy       = (state_q != ST_IDLE);
  assign core_start = (state_q == ST_RUN);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign core_p     = core_p_q;
  assign core_rst_n = core_rst_n_q & rst_n;

endmodule

// File: tb/tb_mont_mul_sched.sv
// Directed bench for mont_mul_sched with a behavioural core of programmable latency.
module tb_mont_mul_sched;

  localparam int W  = 256;
  localparam int TO = 300;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req0_p = '0;
  logic [W-1:0] req1_a = '0, req1_b = '0, req1_p = '0;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;
  logic         core_rst_n, core_start, core_done, busy;
  logic [W-1:0] core_a, core_b, core_p, core_m;

  int           lat_cfg = 0;
  logic [W-1:0] m_cfg = '0;
  logic         done_force = 1'b0;
  int           core_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mont_mul_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_p(req0_p),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_p(req1_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_rst_n(core_rst_n), .core_start(core_start),
    .core_a(core_a), .core_b(core_b), .core_p(core_p),
    .core_m(core_m), .core_done(core_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: counts RUN cycles since its last clear; done on RUN cycle index lat_cfg-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           core_cnt <= 0;
    else if (!core_rst_n) core_cnt <= 0;
    else if (core_start)  core_cnt <= core_cnt + 1;
  end
  assign core_done = done_force | (core_start && lat_cfg != 0 && core_cnt >= lat_cfg - 1);
  assign core_m    = m_cfg;

  typedef struct {
    logic [1:0]   vld;
    logic [W-1:0] a, b, p;
    int           lat;
    logic [W-1:0] m;
    logic         id;
    logic         err;
    logic [W-1:0] data;
    int           run;
  } vec_t;

  localparam logic [W-1:0] OFS = W'(256);

  vec_t vecs[7];

  function automatic logic [W-1:0] ext(input logic [63:0] x);
    return W'(x);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at the CLEAR-cycle negedge; returns at the first negedge with rsp_valid.
  task automatic wait_rsp(output int run, output int clr, output bit ok);
    run = 0; clr = 0; ok = 1'b0;
    for (int i = 0; i < TO + 50; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      if (!core_rst_n) clr++;
      if (core_start)  run++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int run, clr;
    bit ok;
    logic [W-1:0] ea, eb, ep;
    ea = v.id ? v.a + OFS : v.a;
    eb = v.id ? v.b + OFS : v.b;
    ep = v.id ? v.p + OFS : v.p;
    @(negedge clk);
    req0_a = v.a; req0_b = v.b; req0_p = v.p;
    req1_a = v.a + OFS; req1_b = v.b + OFS; req1_p = v.p + OFS;
    lat_cfg = v.lat; m_cfg = v.m; rsp_ready = 1'b0;
    req0_valid = v.vld[0]; req1_valid = v.vld[1];
    #1;
    chk("grant_ready0", ext(req0_ready), ext(v.id == 1'b0));
    chk("grant_ready1", ext(req1_ready), ext(v.id == 1'b1));
    @(negedge clk);
    #1;
    chk("clear_ready_low", ext({req1_ready, req0_ready}), ext(2'b00));
    chk("core_a", core_a, ea);
    chk("core_b", core_b, eb);
    chk("core_p", core_p, ep);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(run, clr, ok);
    chk("rsp_seen", ext(ok), ext(1'b1));
    chk("run_cycles", ext(run), ext(v.run));
    chk("clear_cycles", ext(clr), ext(1));
    chk("rsp_id", ext(rsp_id), ext(v.id));
    chk("rsp_err", ext(rsp_err), ext(v.err));
    chk("rsp_data", rsp_data, v.data);
    chk("resp_core_start", ext(core_start), ext(1'b0));
    chk("resp_core_a", core_a, ea);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("idle_rsp_valid", ext(rsp_valid), ext(1'b0));
    chk("idle_busy", ext(busy), ext(1'b0));
  endtask

  initial begin
    int run, clr;
    bit ok;
    vec_t vr;

    vecs[0] = '{2'b11, ext(3), ext(5), ext(7), 273, ext('h1234), 1'b0, 1'b0, ext('h1234), 273};
    vecs[1] = '{2'b11, ext('h11), ext('h22), ext('h33), 5, ext('hBEEF), 1'b1, 1'b0, ext('hBEEF), 5};
    vecs[2] = '{2'b01, ext('hA), ext('hB), ext('hD), 1, {8{32'hCAFEF00D}}, 1'b0, 1'b0, {8{32'hCAFEF00D}}, 1};
    vecs[3] = '{2'b10, ext(1), ext(2), ext('h65), TO, ext('h55), 1'b1, 1'b0, ext('h55), TO};
    vecs[4] = '{2'b01, ext(4), ext(6), ext(9), 0, ext('h77), 1'b0, 1'b1, ext(0), TO};
    vecs[5] = '{2'b11, ext(8), ext(9), ext('hB), TO + 1, ext('h99), 1'b1, 1'b1, ext(0), TO};
    vecs[6] = '{2'b11, ext('h21), ext('h43), ext('h65), 2, ext('h4321), 1'b0, 1'b0, ext('h4321), 2};

    // Reset state, with a request pending to confirm ready stays low.
    req0_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready0", ext(req0_ready), ext(1'b0));
    chk("rst_busy", ext(busy), ext(1'b0));
    chk("rst_core_rst_n", ext(core_rst_n), ext(1'b0));
    chk("rst_rsp_valid", ext(rsp_valid), ext(1'b0));
    chk("rst_core_start", ext(core_start), ext(1'b0));
    chk("rst_core_a", core_a, ext(0));
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_core_rst_n", ext(core_rst_n), ext(1'b1));

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Response held: outputs stable, other requester held off; done ignored outside RUN.
    @(negedge clk);
    done_force = 1'b1; m_cfg = ext('hA5A5);
    req0_a = ext('h10); req0_b = ext('h20); req0_p = ext('h30);
    req0_valid = 1'b1;
    #1 chk("hold_grant0", ext(req0_ready), ext(1'b1));
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(run, clr, ok);
    chk("hold_rsp_seen", ext(ok), ext(1'b1));
    chk("hold_run_cycles", ext(run), ext(1));
    chk("hold_rsp_data", rsp_data, ext('hA5A5));
    m_cfg = ext('hFFFF);
    req1_a = ext('h1); req1_b = ext('h2); req1_p = ext('h3);
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_rsp_valid", ext(rsp_valid), ext(1'b1));
      chk("hold_data_stable", rsp_data, ext('hA5A5));
      chk("hold_id_stable", ext({rsp_err, rsp_id}), ext(2'b00));
      chk("hold_req1_ready", ext(req1_ready), ext(1'b0));
      chk("hold_core_a", core_a, ext('h10));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 chk("handshake_no_grant", ext(req1_ready), ext(1'b0));
    @(negedge clk);
    rsp_ready = 1'b0; done_force = 1'b0; lat_cfg = 3;
    #1 chk("after_resp_grant1", ext(req1_ready), ext(1'b1));
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(run, clr, ok);
    chk("queued_rsp_seen", ext(ok), ext(1'b1));
    chk("queued_run_cycles", ext(run), ext(3));
    chk("queued_rsp_id", ext(rsp_id), ext(1'b1));
    chk("queued_rsp_data", rsp_data, ext('hFFFF));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset in the middle of RUN abandons the operation.
    lat_cfg = 0;
    req0_a = ext('h5); req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrun_core_start", ext(core_start), ext(1'b1));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", ext(busy), ext(1'b0));
    chk("midrst_core_start", ext(core_start), ext(1'b0));
    chk("midrst_core_rst_n", ext(core_rst_n), ext(1'b0));
    chk("midrst_core_a", core_a, ext(0));
    chk("midrst_rsp", ext({rsp_valid, rsp_err, rsp_id}), ext(3'b000));
    chk("midrst_rsp_data", rsp_data, ext(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("postrst_no_rsp", ext(rsp_valid), ext(1'b0));
    chk("postrst_busy", ext(busy), ext(1'b0));
    chk("postrst_core_rst_n", ext(core_rst_n), ext(1'b1));
    vr = '{2'b11, ext('h7), ext('h8), ext('h9), 7, ext('h600D), 1'b0, 1'b0, ext('h600D), 7};
    run_vec(vr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mont_mul_sched.md
MONT_MUL_SCHED -- requirements
Module: mont_mul_sched

Interface
REQ-001 Parameters SHALL be: WIDTH, 256, operand/result width; TIMEOUT, 300, maximum RUN cycles before abort.
REQ-002 Ports SHALL be as follows:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset; the block has one clock, and reset is asynchronous and active-low.
- reqN_valid  in  1  requester N (N=0,1) has an operation pending.
- reqN_ready  out  1  requester N operands accepted this cycle.
- reqN_a, reqN_b, reqN_p  in  WIDTH  requester N operands A, B, modulus P.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that owns the result.
- rsp_data  out  WIDTH  Montgomery product.
- rsp_err  out  1  result aborted by timeout; rsp_data is 0.
- core_rst_n  out  1  registered clear to the multiplier core, active-low.
- core_start  out  1  level run enable to the core.
- core_a, core_b, core_p  out  WIDTH  latched operands to the core.
- core_m  in  WIDTH  core result.
- core_done  in  1  core completion flag (level).
- busy  out  1  high in any state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, RUN, RESP.
REQ-004 IDLE: if any reqN_valid, SHALL grant exactly one requester, pulse its reqN_ready for one cycle, latch its a/b/p into core_a/b/p, record rsp_id, go to CLEAR.
REQ-005 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; the last-grant pointer updates only on grant.
REQ-006 reqN_ready SHALL be asserted only in IDLE, and never for both requesters in the same cycle.
REQ-007 CLEAR: core_rst_n SHALL be low for exactly one cycle and core_start low; next state RUN.
REQ-008 RUN: core_start SHALL be held high and a cycle counter incremented from 0 each cycle.
REQ-009 In RUN, the first cycle with core_done=1 SHALL capture core_m into rsp_data, set rsp_err=0, and go to RESP.
REQ-010 In RUN, if the counter reaches TIMEOUT without core_done, the block SHALL set rsp_err=1 and rsp_data=0, and go to RESP.
REQ-011 core_done SHALL be ignored outside RUN.
REQ-012 core_done asserted on the same cycle the counter reaches TIMEOUT SHALL count as success (REQ-009 wins).
REQ-013 RESP: core_start SHALL be low, and rsp_valid high with rsp_data/rsp_id/rsp_err stable until rsp_ready.
REQ-014 rsp_valid&rsp_ready in RESP SHALL return to IDLE; no new grant is issued in that same cycle.
REQ-015 Minimum request-to-response latency SHALL be grant cycle + 1 CLEAR cycle + core latency + 1 capture cycle.
REQ-016 core_a/b/p SHALL remain constant from grant until leaving RESP.
REQ-017 Requests arriving while busy SHALL be held off (ready low); the block has no queue.

Reset
REQ-018 On rst_n low, asynchronously: state=IDLE; last-grant pointer=1 (req0 wins first tie); counter=0.
REQ-019 All outputs SHALL be 0 during reset except core_rst_n, which SHALL be 0 (core held cleared).
REQ-020 After reset release, core_rst_n SHALL be 1 except in CLEAR.
REQ-021 Reset mid-RUN or mid-RESP SHALL abandon the operation with no response.

Structure
REQ-022 The shared package SHALL hold the state enum, WIDTH default and TIMEOUT default.
REQ-023 The round-robin grant logic SHALL be one sub-module, rr_arb2, combinational grant plus registered pointer.
REQ-024 The multiplier core is instantiated outside this block; core_rst_n is ANDed with rst_n at the top level.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- req0 A=3,B=5,P=7, core model done after 273 cycles with M=0x1234: rsp_valid, rsp_id=0, rsp_data=0x1234, rsp_err=0.
- req0 and req1 valid together from reset, then again together: grants req0, then req1 (alternation).
- Core model never asserts done: rsp_err=1, rsp_data=0 exactly TIMEOUT RUN cycles after CLEAR.
- rsp_ready held low 10 cycles in RESP: rsp_* stable; req1_valid high meanwhile gets no ready.
- core_done on the TIMEOUT cycle: rsp_err=0 and data captured.
- rst_n low mid-RUN: all outputs 0 next edge; a new request after release completes normally.
